// File: rtl/mem_load_sequencer_pkg.sv
// Shared load-path definitions: load type codes, sequencer state encoding,
// and the alignment legality rule used by the sequencer.
package mem_load_sequencer_pkg;

    localparam logic [1:0] LT_WORD = 2'b00;
    localparam logic [1:0] LT_HALF = 2'b01;
    localparam logic [1:0] LT_BYTE = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_DONE = 2'b10,
        S_ERR  = 2'b11
    } seq_state_e;

    // Type 2'b11 falls into the word rule, so it is checked like a word load.
    function automatic logic is_misaligned(input logic [1:0] lt, input logic [1:0] off);
        case (lt)
            LT_HALF: is_misaligned = off[0];
            LT_BYTE: is_misaligned = 1'b0;
            default: is_misaligned = (off != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_load_sequencer_lane_align.sv
// Combinational lane aligner: moves the addressed halfword/byte of a
// little-endian read word into the top bits, zero-filling below it.
module load_lane_align
    import mem_load_sequencer_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  type_i,
    input  logic [1:0]  offset_i,
    output logic [31:0] aligned_o
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    // Byte lane k lives at bits 8k+7:8k; halfword lane uses offset bit 1 only.
    assign half_sel = rdata_i[{offset_i[1], 4'b0000} +: 16];
    assign byte_sel = rdata_i[{offset_i, 3'b000} +: 8];

    always_comb begin
        aligned_o = rdata_i;
        case (type_i)
            LT_HALF: aligned_o = {half_sel, 16'h0000};
            LT_BYTE: aligned_o = {byte_sel, 24'h000000};
            default: aligned_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_load_sequencer.sv
// Multicycle load front-end: issues a word-aligned read, waits a fixed
// latency, captures and lane-aligns the result for the load mask.
module mem_load_sequencer
    import mem_load_sequencer_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [31:0] addr_i,
    input  logic [1:0]  load_type_i,
    output logic [31:0] mem_addr_o,
    output logic        mem_wr_o,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] mdr_out_o,
    output logic [1:0]  ct_out_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        misaligned_o
);

    localparam int CW = ($clog2(MEM_LATENCY + 1) < 1) ? 1 : $clog2(MEM_LATENCY + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LATENCY - 1);

    seq_state_e     state_q;
    logic [31:2]    addr_q;
    logic [1:0]     type_q;
    logic [1:0]     off_q;
    logic [CW-1:0]  cnt_q;
    logic [31:0]    mdr_q;
    logic [31:0]    mdr_d;
    logic [1:0]     ct_q;
    logic           busy_q;
    logic           done_q;
    logic           misaligned_q;

    load_lane_align u_align (
        .rdata_i   (mem_rdata_i),
        .type_i    (type_q),
        .offset_i  (off_q),
        .aligned_o (mdr_d)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            type_q       <= LT_WORD;
            off_q        <= 2'b00;
            cnt_q        <= '0;
            mdr_q        <= '0;
            ct_q         <= LT_WORD;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            done_q       <= 1'b0;
            misaligned_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        addr_q <= addr_i[31:2];
                        type_q <= load_type_i;
                        off_q  <= addr_i[1:0];
                        busy_q <= 1'b1;
                        if (is_misaligned(load_type_i, addr_i[1:0])) begin
                            state_q      <= S_ERR;
                            misaligned_q <= 1'b1;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        mdr_q   <= mdr_d;
                        ct_q    <= type_q;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                // DONE and ERR each last exactly one cycle; start is not sampled here.
                S_DONE, S_ERR: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_addr_o   = {addr_q, 2'b00};
    assign mem_wr_o     = 1'b0;
    assign mdr_out_o    = mdr_q;
    assign ct_out_o     = ct_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign misaligned_o = misaligned_q;

endmodule
